// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, step mode.
// Imported by the unit, its step datapath and the ID-stage decode.
package ex_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle for the mul/div unit: launch request, operands, MTHI/MTLO writes, results.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_md_step.sv
// One iteration of the mul/div datapath on the {hi,lo} accumulator: right-shifting
// shift-add for multiply, left-shifting restoring subtract for divide.
module md_step
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_e         mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // Shifted partial remainder needs one extra bit: it can reach 2*divisor-1.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, operand};
        acc_next = acc;
        if (mode == STEP_MUL) begin
            if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
            else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else              acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle on magnitudes,
// sign fix-up in a final cycle, busy held for the hazard logic while an operation is in flight.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clock,
    input logic        reset,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e          state;
    logic [CNT_W-1:0]   cnt;
    md_op_e             op_q;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    md_op_e             in_op;
    logic               in_sa;
    logic               in_sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    step_mode_e         step_mode;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;
    logic               dbz_fix;

    always_comb begin
        in_op     = md_op_e'(bus.op);
        in_sa     = op_is_signed(in_op) & bus.src_a[WIDTH-1];
        in_sb     = op_is_signed(in_op) & bus.src_b[WIDTH-1];
        mag_a     = in_sa ? -bus.src_a : bus.src_a;
        mag_b     = in_sb ? -bus.src_b : bus.src_b;
        step_mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;
    end

    md_step #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Sign fix-up: sign_a/sign_b are already zero for the unsigned ops.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        dbz_fix  = 1'b0;
        if (op_is_div(op_q)) begin
            if (operand == '0) begin
                hi_fix  = a_raw;
                lo_fix  = '1;
                dbz_fix = 1'b1;
            end else begin
                hi_fix  = rem_fix;
                lo_fix  = quot_fix;
            end
        end
    end

    always_ff @(posedge clock) begin
        done_q <= 1'b0;
        dbz_q  <= 1'b0;
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start && !bus.flush) begin
                        state   <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        op_q    <= in_op;
                        sign_a  <= in_sa;
                        sign_b  <= in_sb;
                        a_raw   <= bus.src_a;
                        acc     <= {{WIDTH{1'b0}}, op_is_div(in_op) ? mag_a : mag_b};
                        operand <= op_is_div(in_op) ? mag_b : mag_a;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        done_q <= 1'b1;
                        dbz_q  <= dbz_fix;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized checks of ex_muldiv against a plain-arithmetic HI/LO reference.
module tb_ex_muldiv;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic (SV division truncates toward zero).
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, sq, sr;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = 64'(a) * 64'(b);
            default: p = '0;
        endcase
        eh = p[63:32];
        el = p[31:0];
        if (op[1]) begin
            if (b == 32'd0) begin
                eh = a;
                el = 32'hFFFF_FFFF;
                ed = 1'b1;
            end else if (op == 2'b10) begin
                sq = sa / sb;
                sr = sa % sb;
                q = 64'(sq);
                r = 64'(sr);
                el = q[31:0];
                eh = r[31:0];
            end else begin
                el = a / b;
                eh = a % b;
            end
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges until done; early_drop flags busy falling before the result.
    task automatic wait_done(output int cyc, output logic early_drop);
        cyc = 0;
        early_drop = 1'b0;
        while (!bus.done && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (!bus.done && !bus.busy) early_drop = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic ed;
        model(op, a, b, eh, el, ed);
        chk({tag, "_done"}, 64'(bus.done), 64'(1));
        chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'(0));
        @(posedge clock);
        #1;
        chk({tag, "_done_1cyc"}, 64'(bus.done), 64'(0));
        chk({tag, "_dbz_1cyc"}, 64'(bus.div_by_zero), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic early;
        launch(op, a, b);
        chk({tag, "_busy_start"}, 64'(bus.busy), 64'(1));
        wait_done(cyc, early);
        chk({tag, "_latency"}, 64'(cyc), 64'(W + 1));
        chk({tag, "_busy_held"}, 64'(early), 64'(0));
        check_result(tag, op, a, b);
    endtask

    initial begin
        logic [31:0] h0, l0, ra, rb;
        logic [1:0]  rop;
        int          cyc, seen;
        logic        early;

        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        chk("rst_hilo", {bus.hi, bus.lo}, 64'(0));

        // Directed results
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_max_lo_const", 64'(bus.lo), 64'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("divu_zero", 2'b11, 32'h1234, 32'd0);
        run_op("div_zero_neg", 2'b10, 32'h8000_0005, 32'd0);
        run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_rem_neg", 2'b10, 32'hFFFF_FF9C, 32'd7);
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);

        // Reset in the middle of RUN
        launch(2'b00, 32'h1357_9BDF, 32'h0246_8ACE);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        run_op("after_rst", 2'b01, 32'h0001_0000, 32'h0003_0000);

        // Flush at RUN cycle 10
        h0 = bus.hi;
        l0 = bus.lo;
        launch(2'b10, 32'h7654_3210, 32'h0000_0123);
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) seen++;
        end
        chk("flush_no_done", 64'(seen), 64'(0));
        chk("flush_hilo_kept", {bus.hi, bus.lo}, {h0, l0});

        // Flush together with start in IDLE
        @(negedge clock);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01;
        @(posedge clock);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_idle", 64'(bus.busy), 64'(0));

        // Start and MTHI while busy are ignored
        launch(2'b00, 32'h1234_5678, 32'hFFFF_9ABC);
        h0 = bus.hi;
        repeat (4) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1; bus.src_b = 32'd0;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        chk("busy_hi_we_ignored", 64'(bus.hi), 64'(h0));
        wait_done(cyc, early);
        chk("restart_latency", 64'(cyc + 5), 64'(W + 1));
        check_result("restart_ignored", 2'b00, 32'h1234_5678, 32'hFFFF_9ABC);

        // MTLO / MTHI in IDLE
        @(negedge clock);
        bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(posedge clock);
        #1;
        bus.lo_we = 1'b0;
        chk("mtlo", 64'(bus.lo), 64'hA5A5_A5A5);
        @(negedge clock);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0F0F_1234;
        @(posedge clock);
        #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h0F0F_1234, 32'h0F0F_1234});

        // MTHI in the same cycle as start: lands now, result overwrites later
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd33;
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFE_0001;
        @(posedge clock);
        #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        chk("mthi_with_start", 64'(bus.hi), 64'hCAFE_0001);
        wait_done(cyc, early);
        chk("mthi_start_latency", 64'(cyc), 64'(W + 1));
        check_result("mthi_start_result", 2'b11, 32'd1000, 32'd33);

        // Randomized operations
        for (int k = 0; k < 24; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", k), rop, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
